// File: rtl/ibex_pkg.sv
// ibex_pkg
//   Shared types for the writeback retire queue.
//   wb_instr_type_e : class of instruction held in writeback (load/store/other).
//   wb_entry_t      : one retire-queue entry (control flags plus payload).
package ibex_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    typedef struct packed {
        logic           valid;
        wb_instr_type_e itype;
        logic [31:0]    pc;
        logic           compressed;
        logic           count;
        logic [4:0]     waddr;
        logic           we;
        logic [31:0]    data;
        logic           resp;
        logic           err;
    } wb_entry_t;

endpackage

// File: rtl/ibex_wb_fwd_search.sv
// ibex_wb_fwd_search
//   Youngest-match forwarding search for one register-file read port.
//   entries_i    : all queue entries (valid entries are contiguous head..tail-1)
//   tail_i       : queue tail pointer (next free slot)
//   raddr_i      : read address from ID
//   fwd_valid_o  : matching entry holds usable data
//   fwd_data_o   : that data (0 when fwd_valid_o is low)
//   hazard_o     : matching entry's data is not yet available
module ibex_wb_fwd_search
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  wb_entry_t [Depth-1:0] entries_i,
    input  logic [PtrW-1:0]       tail_i,
    input  logic [4:0]            raddr_i,
    output logic                  fwd_valid_o,
    output logic [31:0]           fwd_data_o,
    output logic                  hazard_o
);

    logic      found;
    wb_entry_t hit;
    logic [PtrW-1:0] idx;

    // Walk from the youngest slot (tail-1) towards the oldest; the first
    // valid writer of raddr_i is the one whose value ID must observe.
    always_comb begin
        found = 1'b0;
        hit   = '0;
        idx   = '0;
        for (int k = 1; k <= Depth; k++) begin
            idx = tail_i - PtrW'(k);
            if (!found && entries_i[idx].valid && entries_i[idx].we &&
                (entries_i[idx].waddr == raddr_i) && (raddr_i != 5'd0)) begin
                found = 1'b1;
                hit   = entries_i[idx];
            end
        end
    end

    always_comb begin
        fwd_valid_o = 1'b0;
        fwd_data_o  = 32'd0;
        hazard_o    = 1'b0;
        if (found) begin
            if ((hit.itype == WB_INSTR_OTHER) ||
                ((hit.itype == WB_INSTR_LOAD) && hit.resp && !hit.err)) begin
                fwd_valid_o = 1'b1;
                fwd_data_o  = hit.data;
            end else begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibex_wb_queue.sv
// ibex_wb_queue
//   Depth-entry in-order writeback retire queue with read-port forwarding and
//   arbitration of auxiliary register-file writers onto the single RF port.
//   Inputs : ID/EX offer (en_wb_i, type, pc, flags, rf_waddr/wdata/we),
//            LSU responses (in program order), auxiliary write requests,
//            two ID read addresses.
//   Outputs: ready_wb_o, ext_gnt_o, per-port forward/hazard, RF write port,
//            outstanding load/store flags, occupancy, head PC, retire and
//            perf-counter strobes.
module ibex_wb_queue
    import ibex_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter int unsigned NumExtSrc = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    en_wb_i,
    input  wb_instr_type_e          instr_type_wb_i,
    input  logic [31:0]             pc_id_i,
    input  logic                    instr_is_compressed_id_i,
    input  logic                    instr_perf_count_id_i,
    input  logic [4:0]              rf_waddr_id_i,
    input  logic [31:0]             rf_wdata_id_i,
    input  logic                    rf_we_id_i,
    output logic                    ready_wb_o,

    input  logic                    lsu_resp_valid_i,
    input  logic                    lsu_resp_err_i,
    input  logic [31:0]             rf_wdata_lsu_i,

    input  logic [NumExtSrc-1:0]    ext_req_i,
    input  logic [NumExtSrc*5-1:0]  ext_waddr_i,
    input  logic [NumExtSrc*32-1:0] ext_wdata_i,
    output logic [NumExtSrc-1:0]    ext_gnt_o,

    input  logic [4:0]              rf_raddr_a_i,
    input  logic [4:0]              rf_raddr_b_i,
    output logic                    fwd_valid_a_o,
    output logic                    fwd_valid_b_o,
    output logic [31:0]             fwd_data_a_o,
    output logic [31:0]             fwd_data_b_o,
    output logic                    hazard_a_o,
    output logic                    hazard_b_o,

    output logic                    rf_we_wb_o,
    output logic [4:0]              rf_waddr_wb_o,
    output logic [31:0]             rf_wdata_wb_o,

    output logic                    outstanding_load_wb_o,
    output logic                    outstanding_store_wb_o,
    output logic [$clog2(Depth+1)-1:0] occupancy_o,
    output logic [31:0]             pc_wb_o,
    output logic                    instr_done_wb_o,
    output logic                    perf_instr_ret_wb_o,
    output logic                    perf_instr_ret_compressed_wb_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    // Depth is a power of two, so natural pointer overflow wraps correctly
    // except for the single-entry case where the pointer is pinned to 0.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (Depth == 1) return '0;
        return p + PtrW'(1);
    endfunction

    wb_entry_t [Depth-1:0] entries_q, entries_d;
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic                  mem_found;
    logic [PtrW-1:0]       mem_idx;
    logic [PtrW-1:0]       scan_idx;

    wb_entry_t             head_e;
    logic                  resp_now_head;
    logic                  head_done, head_err, head_wr;
    logic [31:0]           head_data;
    logic                  push, pop;

    logic                  ext_any;
    logic [$clog2(NumExtSrc+1)-1:0] ext_sel;

    // Oldest valid memory op still waiting on the LSU. Scanning from the
    // youngest offset down lets the oldest one override.
    always_comb begin
        mem_found = 1'b0;
        mem_idx   = head_q;
        scan_idx  = head_q;
        for (int k = Depth - 1; k >= 0; k--) begin
            scan_idx = head_q + PtrW'(k);
            if (entries_q[scan_idx].valid &&
                (entries_q[scan_idx].itype != WB_INSTR_OTHER) &&
                !entries_q[scan_idx].resp) begin
                mem_found = 1'b1;
                mem_idx   = scan_idx;
            end
        end
    end

    assign head_e        = entries_q[head_q];
    assign resp_now_head = lsu_resp_valid_i & mem_found & (mem_idx == head_q);
    assign head_done     = head_e.valid &
                           ((head_e.itype == WB_INSTR_OTHER) | head_e.resp | resp_now_head);
    assign head_err      = resp_now_head ? lsu_resp_err_i : head_e.err;
    assign head_data     = (resp_now_head && (head_e.itype == WB_INSTR_LOAD)) ?
                           rf_wdata_lsu_i : head_e.data;
    assign head_wr       = head_done & head_e.we & ~head_err;

    // A full queue still accepts when its head leaves in the same cycle.
    assign ready_wb_o = (count_q < CntW'(Depth)) | head_done;
    assign push       = en_wb_i & ready_wb_o;
    assign pop        = head_done;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (lsu_resp_valid_i && mem_found) begin
            entries_d[mem_idx].resp = 1'b1;
            entries_d[mem_idx].err  = lsu_resp_err_i;
            if (entries_q[mem_idx].itype == WB_INSTR_LOAD) begin
                entries_d[mem_idx].data = rf_wdata_lsu_i;
            end
        end

        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = ptr_inc(head_q);
        end

        // Applied after pop: when full, tail == head and the new entry
        // reuses the slot that is retiring this cycle.
        if (push) begin
            entries_d[tail_q] = '{
                valid:      1'b1,
                itype:      instr_type_wb_i,
                pc:         pc_id_i,
                compressed: instr_is_compressed_id_i,
                count:      instr_perf_count_id_i,
                waddr:      rf_waddr_id_i,
                we:         rf_we_id_i | (instr_type_wb_i == WB_INSTR_LOAD),
                data:       rf_wdata_id_i,
                resp:       1'b0,
                err:        1'b0
            };
            tail_d = ptr_inc(tail_q);
        end

        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Only the control flags are reset; payload fields are don't-care while
    // their entry is invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].resp  <= 1'b0;
                entries_q[i].err   <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // Auxiliary writers only use the port when the head is not writing;
    // the lowest index wins.
    always_comb begin
        ext_gnt_o = '0;
        ext_any   = 1'b0;
        ext_sel   = '0;
        if (!head_wr) begin
            for (int i = NumExtSrc - 1; i >= 0; i--) begin
                if (ext_req_i[i]) begin
                    ext_gnt_o = '0;
                    ext_gnt_o[i] = 1'b1;
                    ext_any   = 1'b1;
                    ext_sel   = ($clog2(NumExtSrc+1))'(i);
                end
            end
        end
    end

    always_comb begin
        rf_we_wb_o    = head_wr | ext_any;
        rf_waddr_wb_o = 5'd0;
        rf_wdata_wb_o = 32'd0;
        if (head_wr) begin
            rf_waddr_wb_o = head_e.waddr;
            rf_wdata_wb_o = head_data;
        end else if (ext_any) begin
            rf_waddr_wb_o = ext_waddr_i[ext_sel*5 +: 5];
            rf_wdata_wb_o = ext_wdata_i[ext_sel*32 +: 32];
        end
    end

    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (entries_q[i].valid && (entries_q[i].itype == WB_INSTR_LOAD)) begin
                outstanding_load_wb_o = 1'b1;
            end
            if (entries_q[i].valid && (entries_q[i].itype == WB_INSTR_STORE)) begin
                outstanding_store_wb_o = 1'b1;
            end
        end
    end

    assign occupancy_o                    = count_q;
    assign pc_wb_o                        = head_e.valid ? head_e.pc : 32'd0;
    assign instr_done_wb_o                = head_done;
    assign perf_instr_ret_wb_o            = head_done & head_e.count & ~head_err;
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_e.compressed;

    ibex_wb_fwd_search #(.Depth(Depth), .PtrW(PtrW)) u_fwd_a (
        .entries_i   (entries_q),
        .tail_i      (tail_q),
        .raddr_i     (rf_raddr_a_i),
        .fwd_valid_o (fwd_valid_a_o),
        .fwd_data_o  (fwd_data_a_o),
        .hazard_o    (hazard_a_o)
    );

    ibex_wb_fwd_search #(.Depth(Depth), .PtrW(PtrW)) u_fwd_b (
        .entries_i   (entries_q),
        .tail_i      (tail_q),
        .raddr_i     (rf_raddr_b_i),
        .fwd_valid_o (fwd_valid_b_o),
        .fwd_data_o  (fwd_data_b_o),
        .hazard_o    (hazard_b_o)
    );

    a_single_src: assert property (@(posedge clk_i) disable iff (rst_i)
        rf_we_wb_o |-> (head_wr ^ ext_any));
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ext_gnt_o));
    a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        lsu_resp_valid_i |-> mem_found);

endmodule
